core_id_stage: RTL and testbench
================================

Name: core_id_stage

Overview:
- Instruction-decode/operand stage directly upstream of the register file.
- Accepts fetched instructions over valid/ready and drives the regfile read addresses.
- Merges read data with writeback bypass and tracks in-flight destination registers in a scoreboard.
- Issues operand-complete instructions into a registered ID/EX output with valid/ready.

Parameters:
- CONF, config_t (config_pkg default), core configuration; CONF.XLEN sets the data/PC width.

Ports:
- clk, input, 1, core clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, fetch presents an instruction.
- in_ready, output, 1, stage accepts this cycle.
- in_instr, input, 32, instruction word.
- in_pc, input, XLEN, instruction PC.
- rf_a0 / rf_a1, output, 5 each, regfile read addresses (rs1 / rs2).
- rf_rd0 / rf_rd1, input, XLEN each, regfile read data.
- wb_valid, input, 1, an issued instruction retires; clears pending for wb_addr.
- wb_we, input, 1, the retire carries write data; valid only with wb_valid.
- wb_addr, input, 5, retiring rd.
- wb_data, input, XLEN, retiring result.
- flush, input, 1, kill the ID-held and output instructions.
- out_valid, output, 1, ID/EX register holds an instruction.
- out_ready, input, 1, EX accepts.
- out_pc, output, XLEN, registered PC.
- out_instr, output, 32, registered instruction.
- out_rs1_val / out_rs2_val, output, XLEN each, registered operands.
- out_rd, output, 5, destination register; 0 if the instruction writes no register.
- out_imm, output, XLEN, decoded immediate (see optional feature).
- Clock/reset: one clock, clk; reset is asynchronous and active-low, rst_n.

Behaviour:
- Reset: id_valid=0, out_valid=0, all out_* registers=0, scoreboard=0. in_ready=1 the first cycle after reset.
- ID latch: captures in_instr/in_pc on in_valid&&in_ready. in_ready = !id_valid || id_adv.
- rf_a0 = id_instr[19:15], rf_a1 = id_instr[24:20], combinational from the latch.
- Source use:
  - rs1 is used unless opcode is LUI, AUIPC or JAL.
  - rs2 is used only for OP (0110011), STORE and BRANCH.
  - Register x0 is never hazardous.
- Writes-rd: every opcode except STORE and BRANCH, and only when rd!=0.
- Bypass: if wb_valid&&wb_we&&wb_addr==src&&src!=0, the operand is wb_data; otherwise it is the regfile data.
- Hazard (stall):
  - A used source whose pending bit is set, unless the same-cycle wb_valid matches it.
  - A pending rd is treated the same way (WAW).
- id_adv = id_valid && !hazard && (!out_valid || out_ready) && !flush.
- id_adv loads the output register; out_valid=1 the next cycle.
- Otherwise out_valid is cleared when out_ready is high; out_* holds while out_valid && !out_ready.
- Latency: accepted at cycle N, earliest out_valid at N+2. Throughput is 1 per cycle with no hazards.
- Scoreboard (32 bits):
  - Set bit rd on id_adv when the instruction writes rd.
  - Clear bit wb_addr on wb_valid.
  - Set and clear of the same bit in the same cycle: set wins.
  - Bit 0 is always 0.
- Flush:
  - Next cycle id_valid=0 and out_valid=0; an in_valid in the flush cycle is dropped.
  - Flush does not touch the scoreboard.
  - Downstream guarantees exactly one wb_valid per issued writes-rd instruction, with wb_we=0 for killed ones.
- Reset mid-operation: everything returns to the reset state immediately (asynchronous).

Optional Feature:
- CORE_ID_IMM_EN defined:
  - out_imm is the sign-extended I/S/B/U/J immediate selected by opcode, registered with the other outputs.
  - It is 0 for OP.
- Undefined: out_imm is constant 0; EX decodes the immediate itself.

Decomposition:
- config_pkg gains:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_BRANCH, OPC_STORE, OPC_OP, ...);
  - the packed id_ex_t (pc, instr, rs1_val, rs2_val, rd, imm).
- Sub-module core_scoreboard: the 32-bit pending vector, set/clear ports, and the hazard lookup with same-cycle-clear override.

Test Plan:
- Three ADDs, independent, out_ready=1 -> first out_valid at cycle 2, then one per cycle; operands equal the regfile values.
- LW x5 issued, then ADD x6,x5,x1 -> ADD stalls with in_ready=0. Pulse wb_valid/wb_we, x5=0x1234 -> ADD issues that cycle with out_rs1_val=0x1234.
- out_ready=0 for 4 cycles with a valid out -> out_* stable, in_ready=0 once the ID latch fills; no instruction lost.
- ADD x0,... then SW x0 -> out_rd=0, scoreboard unchanged; SW rs2 hazard on x0 never stalls.
- flush during a stall with scoreboard bit x7 set -> out_valid=0 and id_valid=0 next cycle; bit 7 stays set until wb_valid with wb_addr=7 and wb_we=0.
- rst_n low mid-stream -> all outputs 0 immediately, scoreboard 0, in_ready=1 after release.

Source files
------------

// File: rtl/config_pkg.sv
// Core configuration, RV32 opcode constants, ID/EX payload and immediate decoder.
package config_pkg;

    typedef struct packed {
        int unsigned XLEN;
    } config_t;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned ILEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NREGS    = 32;

    localparam config_t DEFAULT_CONF = '{XLEN: XLEN_DEF};

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN-1:0]     instr;
        logic [XLEN_DEF-1:0] rs1_val;
        logic [XLEN_DEF-1:0] rs2_val;
        logic [REG_AW-1:0]   rd;
        logic [XLEN_DEF-1:0] imm;
    } id_ex_t;

    // Sign-extended immediate by format; OP has none, everything unlisted is I-type.
    function automatic logic [31:0] decode_imm(input logic [ILEN-1:0] i);
        logic [31:0] imm;
        case (i[6:0])
            OPC_OP:              imm = 32'd0;
            OPC_LUI, OPC_AUIPC:  imm = {i[31:12], 12'd0};
            OPC_JAL:             imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            OPC_BRANCH:          imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OPC_STORE:           imm = {{20{i[31]}}, i[31:25], i[11:7]};
            default:             imm = {{20{i[31]}}, i[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/core_scoreboard.sv
// Pending-destination scoreboard with hazard lookup; a same-cycle retire clears the hazard.
module core_scoreboard
    import config_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_i,
    input  logic [REG_AW-1:0] set_addr_i,
    input  logic              clr_i,
    input  logic [REG_AW-1:0] clr_addr_i,
    input  logic              rs1_en_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic              rs2_en_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic              rd_en_i,
    input  logic [REG_AW-1:0] rd_i,
    output logic              hazard_c_o
);

    logic [NREGS-1:0] pend_q, pend_d;

    function automatic logic busy(input logic [NREGS-1:0] pend, input logic [REG_AW-1:0] a,
                                  input logic clr, input logic [REG_AW-1:0] clr_a);
        return (a != '0) && pend[a] && !(clr && (clr_a == a));
    endfunction

    // Clear first so that a coincident set on the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (clr_i) pend_d[clr_addr_i] = 1'b0;
        if (set_i) pend_d[set_addr_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    assign hazard_c_o = (rs1_en_i && busy(pend_q, rs1_i, clr_i, clr_addr_i))
                     || (rs2_en_i && busy(pend_q, rs2_i, clr_i, clr_addr_i))
                     || (rd_en_i  && busy(pend_q, rd_i,  clr_i, clr_addr_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

endmodule

// File: rtl/core_id_stage.sv
// Decode/operand stage: ID latch, regfile read with writeback bypass, scoreboard stall, ID/EX register.
// Optional: define CORE_ID_IMM_EN to decode and register the immediate onto out_imm.
module core_id_stage
    import config_pkg::*;
#(
    parameter config_t CONF = DEFAULT_CONF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ILEN-1:0]      in_instr,
    input  logic [CONF.XLEN-1:0] in_pc,
    output logic [REG_AW-1:0]    rf_a0,
    output logic [REG_AW-1:0]    rf_a1,
    input  logic [CONF.XLEN-1:0] rf_rd0,
    input  logic [CONF.XLEN-1:0] rf_rd1,
    input  logic                 wb_valid,
    input  logic                 wb_we,
    input  logic [REG_AW-1:0]    wb_addr,
    input  logic [CONF.XLEN-1:0] wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CONF.XLEN-1:0] out_pc,
    output logic [ILEN-1:0]      out_instr,
    output logic [CONF.XLEN-1:0] out_rs1_val,
    output logic [CONF.XLEN-1:0] out_rs2_val,
    output logic [REG_AW-1:0]    out_rd,
    output logic [CONF.XLEN-1:0] out_imm
);

    localparam int unsigned XLEN = CONF.XLEN;

    logic            id_valid_q, id_valid_d;
    logic [ILEN-1:0] id_instr_q, id_instr_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic            out_valid_q, out_valid_d;
    id_ex_t          id_ex_q, id_ex_d;

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              rs1_used, rs2_used, writes_rd;
    logic              hazard_c, id_adv;
    logic [XLEN-1:0]   rs1_val, rs2_val;

    assign opcode = id_instr_q[6:0];
    assign rs1    = id_instr_q[19:15];
    assign rs2    = id_instr_q[24:20];
    assign rd     = id_instr_q[11:7];
    assign rf_a0  = rs1;
    assign rf_a1  = rs2;

    assign rs1_used  = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign rs2_used  = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    assign writes_rd = !((opcode == OPC_STORE) || (opcode == OPC_BRANCH)) && (rd != '0);

    assign rs1_val = (wb_valid && wb_we && (wb_addr == rs1) && (rs1 != '0)) ? wb_data : rf_rd0;
    assign rs2_val = (wb_valid && wb_we && (wb_addr == rs2) && (rs2 != '0)) ? wb_data : rf_rd1;

    core_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (id_adv && writes_rd),
        .set_addr_i (rd),
        .clr_i      (wb_valid),
        .clr_addr_i (wb_addr),
        .rs1_en_i   (rs1_used),
        .rs1_i      (rs1),
        .rs2_en_i   (rs2_used),
        .rs2_i      (rs2),
        .rd_en_i    (writes_rd),
        .rd_i       (rd),
        .hazard_c_o (hazard_c)
    );

    assign id_adv   = id_valid_q && !hazard_c && (!out_valid_q || out_ready) && !flush;
    assign in_ready = !id_valid_q || id_adv;

    // ID latch; anything presented during a flush is dropped.
    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            id_valid_d = 1'b1;
            id_instr_d = in_instr;
            id_pc_d    = in_pc;
        end else if (id_adv) begin
            id_valid_d = 1'b0;
        end
    end

    // ID/EX register: load on advance, drain on out_ready, hold under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        id_ex_d     = id_ex_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (id_adv) begin
            out_valid_d     = 1'b1;
            id_ex_d.pc      = XLEN_DEF'(id_pc_q);
            id_ex_d.instr   = id_instr_q;
            id_ex_d.rs1_val = XLEN_DEF'(rs1_val);
            id_ex_d.rs2_val = XLEN_DEF'(rs2_val);
            id_ex_d.rd      = writes_rd ? rd : '0;
`ifdef CORE_ID_IMM_EN
            id_ex_d.imm     = XLEN_DEF'(decode_imm(id_instr_q));
`else
            id_ex_d.imm     = '0;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid_q  <= 1'b0;
            id_instr_q  <= '0;
            id_pc_q     <= '0;
            out_valid_q <= 1'b0;
            id_ex_q     <= '0;
        end else begin
            id_valid_q  <= id_valid_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            out_valid_q <= out_valid_d;
            id_ex_q     <= id_ex_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = XLEN'(id_ex_q.pc);
    assign out_instr   = id_ex_q.instr;
    assign out_rs1_val = XLEN'(id_ex_q.rs1_val);
    assign out_rs2_val = XLEN'(id_ex_q.rs2_val);
    assign out_rd      = id_ex_q.rd;
`ifdef CORE_ID_IMM_EN
    assign out_imm     = XLEN'(id_ex_q.imm);
`else
    assign out_imm     = '0;
`endif

endmodule

// File: tb/tb_core_id_stage.sv
// Directed bench for core_id_stage; the regfile model returns 0x1000+i for xi and 0 for x0.
module tb_core_id_stage;
    import config_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  rf_a0, rf_a1;
    logic [31:0] rf_rd0, rf_rd1;
    logic        wb_valid = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc, out_instr, out_rs1_val, out_rs2_val, out_imm;
    logic [4:0]  out_rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rf_rd0 = (rf_a0 == 5'd0) ? 32'd0 : 32'h1000 + 32'(rf_a0);
    assign rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : 32'h1000 + 32'(rf_a1);

    core_id_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rf_a0(rf_a0), .rf_a1(rf_a1),
        .rf_rd0(rf_rd0), .rf_rd1(rf_rd1), .wb_valid(wb_valid), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd(out_rd),
        .out_imm(out_imm)
    );

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_we = 1'b0; out_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0h want 0", out_valid); end
        checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL rst_out_pc got %0h want 0", out_pc); end
        checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL rst_out_instr got %0h want 0", out_instr); end
        checks++; if (out_rs1_val !== 32'd0) begin errors++; $display("FAIL rst_rs1 got %0h want 0", out_rs1_val); end
        checks++; if (out_rd !== 5'd0) begin errors++; $display("FAIL rst_rd got %0h want 0", out_rd); end
        checks++; if (out_imm !== 32'd0) begin errors++; $display("FAIL rst_imm got %0h want 0", out_imm); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0h want 1", in_ready); end
    endtask

    task automatic test_independent();
        do_reset();
        in_valid = 1'b1; in_instr = enc_r(5'd1, 5'd2, 5'd3); in_pc = 32'h100;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ind_ready0 got %0h want 1", in_ready); end
        step();
        checks++; if (rf_a0 !== 5'd2) begin errors++; $display("FAIL ind_rf_a0 got %0h want 2", rf_a0); end
        checks++; if (rf_a1 !== 5'd3) begin errors++; $display("FAIL ind_rf_a1 got %0h want 3", rf_a1); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ind_valid1 got %0h want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ind_ready1 got %0h want 1", in_ready); end
        in_instr = enc_r(5'd4, 5'd5, 5'd6); in_pc = 32'h104;
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ind_valid2 got %0h want 1", out_valid); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL ind_pc2 got %0h want 100", out_pc); end
        checks++; if (out_instr !== enc_r(5'd1, 5'd2, 5'd3)) begin errors++; $display("FAIL ind_instr2 got %0h want %0h", out_instr, enc_r(5'd1, 5'd2, 5'd3)); end
        checks++; if (out_rs1_val !== 32'h1002) begin errors++; $display("FAIL ind_rs1_2 got %0h want 1002", out_rs1_val); end
        checks++; if (out_rs2_val !== 32'h1003) begin errors++; $display("FAIL ind_rs2_2 got %0h want 1003", out_rs2_val); end
        checks++; if (out_rd !== 5'd1) begin errors++; $display("FAIL ind_rd2 got %0h want 1", out_rd); end
        in_instr = enc_r(5'd7, 5'd8, 5'd9); in_pc = 32'h108;
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin errors++; $display("FAIL ind_cyc3 got v=%0h pc=%0h want v=1 pc=104", out_valid, out_pc); end
        checks++; if (out_rs1_val !== 32'h1005) begin errors++; $display("FAIL ind_rs1_3 got %0h want 1005", out_rs1_val); end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h108) begin errors++; $display("FAIL ind_cyc4 got v=%0h pc=%0h want v=1 pc=108", out_valid, out_pc); end
        checks++; if (out_rs2_val !== 32'h1009 || out_rd !== 5'd7) begin errors++; $display("FAIL ind_ops4 got rs2=%0h rd=%0h want 1009 7", out_rs2_val, out_rd); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ind_drain got %0h want 0", out_valid); end
    endtask

    task automatic test_raw_bypass();
        do_reset();
        in_valid = 1'b1; in_instr = enc_lw(5'd5, 5'd1, 12'd0); in_pc = 32'h180;
        step();
        in_instr = enc_r(5'd6, 5'd5, 5'd1); in_pc = 32'h184;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_ready1 got %0h want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd5) begin errors++; $display("FAIL raw_lw got v=%0h rd=%0h want 1 5", out_valid, out_rd); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall2 got %0h want 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_bubble got %0h want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall3 got %0h want 0", in_ready); end
        wb_valid = 1'b1; wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release got %0h want 1", in_ready); end
        step();
        wb_valid = 1'b0; wb_we = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h184) begin errors++; $display("FAIL raw_issue got v=%0h pc=%0h want 1 184", out_valid, out_pc); end
        checks++; if (out_rs1_val !== 32'h1234) begin errors++; $display("FAIL raw_bypass got %0h want 1234", out_rs1_val); end
        checks++; if (out_rs2_val !== 32'h1001 || out_rd !== 5'd6) begin errors++; $display("FAIL raw_ops got rs2=%0h rd=%0h want 1001 6", out_rs2_val, out_rd); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = enc_r(5'd1, 5'd2, 5'd3); in_pc = 32'h200;
        step();
        in_instr = enc_r(5'd4, 5'd5, 5'd6); in_pc = 32'h204;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %0h want 1", in_ready); end
        step();
        in_instr = enc_r(5'd7, 5'd8, 5'd9); in_pc = 32'h208;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_rs1_val !== 32'h1002) begin errors++; $display("FAIL bp_hold%0d got v=%0h pc=%0h rs1=%0h want 1 200 1002", i, out_valid, out_pc, out_rs1_val); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold%0d got %0h want 0", i, in_ready); end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_resume got %0h want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h204 || out_rs1_val !== 32'h1005) begin errors++; $display("FAIL bp_b got v=%0h pc=%0h rs1=%0h want 1 204 1005", out_valid, out_pc, out_rs1_val); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h208 || out_rd !== 5'd7) begin errors++; $display("FAIL bp_c got v=%0h pc=%0h rd=%0h want 1 208 7", out_valid, out_pc, out_rd); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0h want 0", out_valid); end
    endtask

    task automatic test_x0();
        logic [31:0] exp_imm;
`ifdef CORE_ID_IMM_EN
        exp_imm = 32'd4;
`else
        exp_imm = 32'd0;
`endif
        do_reset();
        in_valid = 1'b1; in_instr = enc_r(5'd0, 5'd1, 5'd2); in_pc = 32'h300;
        step();
        in_instr = enc_sw(5'd0, 5'd1, 12'd4); in_pc = 32'h304;
        step();
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd0 || out_rs1_val !== 32'h1001) begin errors++; $display("FAIL x0_add got v=%0h rd=%0h rs1=%0h want 1 0 1001", out_valid, out_rd, out_rs1_val); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_sw_nostall got %0h want 1", in_ready); end
        in_instr = enc_r(5'd5, 5'd4, 5'd4); in_pc = 32'h308;
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h304 || out_rd !== 5'd0) begin errors++; $display("FAIL x0_sw got v=%0h pc=%0h rd=%0h want 1 304 0", out_valid, out_pc, out_rd); end
        checks++; if (out_rs2_val !== 32'd0 || out_rs1_val !== 32'h1001) begin errors++; $display("FAIL x0_sw_ops got rs2=%0h rs1=%0h want 0 1001", out_rs2_val, out_rs1_val); end
        checks++; if (out_imm !== exp_imm) begin errors++; $display("FAIL x0_sw_imm got %0h want %0h", out_imm, exp_imm); end
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL x0_sb_clean got %0h want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h308 || out_rs1_val !== 32'h1004) begin errors++; $display("FAIL x0_follow got v=%0h pc=%0h rs1=%0h want 1 308 1004", out_valid, out_pc, out_rs1_val); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = enc_lw(5'd7, 5'd2, 12'd0); in_pc = 32'h400;
        step();
        in_instr = enc_r(5'd8, 5'd7, 5'd1); in_pc = 32'h404;
        step();
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd7) begin errors++; $display("FAIL fl_lw got v=%0h rd=%0h want 1 7", out_valid, out_rd); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_stall got %0h want 0", in_ready); end
        flush = 1'b1; in_instr = enc_r(5'd10, 5'd1, 5'd2); in_pc = 32'h408;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_out_killed got %0h want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_id_killed got %0h want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_dropped got %0h want 0", out_valid); end
        in_valid = 1'b1; in_instr = enc_r(5'd9, 5'd7, 5'd0); in_pc = 32'h40C;
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fl_bit7_a got %0h want 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL fl_bit7_b got v=%0h rdy=%0h want 0 0", out_valid, in_ready); end
        wb_valid = 1'b1; wb_we = 1'b0; wb_addr = 5'd7; wb_data = 32'hDEAD;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_wb_release got %0h want 1", in_ready); end
        step();
        wb_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40C || out_rs1_val !== 32'h1007 || out_rd !== 5'd9) begin errors++; $display("FAIL fl_issue got v=%0h pc=%0h rs1=%0h rd=%0h want 1 40c 1007 9", out_valid, out_pc, out_rs1_val, out_rd); end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = enc_lw(5'd10, 5'd1, 12'd0); in_pc = 32'h500;
        step();
        in_instr = enc_r(5'd11, 5'd2, 5'd3); in_pc = 32'h504;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL ar_pre got v=%0h rdy=%0h want 1 0", out_valid, in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0) begin errors++; $display("FAIL ar_out got v=%0h pc=%0h instr=%0h want 0 0 0", out_valid, out_pc, out_instr); end
        checks++; if (out_rd !== 5'd0 || out_rs1_val !== 32'd0 || rf_a0 !== 5'd0) begin errors++; $display("FAIL ar_regs got rd=%0h rs1=%0h a0=%0h want 0 0 0", out_rd, out_rs1_val, rf_a0); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_ready got %0h want 1", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = enc_r(5'd12, 5'd10, 5'd10); in_pc = 32'h508;
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_sb_cleared got %0h want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h508 || out_rs1_val !== 32'h100A) begin errors++; $display("FAIL ar_issue got v=%0h pc=%0h rs1=%0h want 1 508 100a", out_valid, out_pc, out_rs1_val); end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_independent();
        test_raw_bypass();
        test_backpressure();
        test_x0();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
